// File: rtl/packet_source.sv
// Flit-channel packet generator: header {dest, seq}, PKT_LEN-1 counting body flits, GAP idle cycles.
// Optional XOR checksum tail flit when PACKET_SOURCE_CHECKSUM_EN is defined.
module packet_source #(
  parameter int unsigned SIZE         = 8,
  parameter int unsigned CHANNEL_BITS = 3,
  parameter int unsigned PKT_LEN      = 4,
  parameter int unsigned GAP          = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [CHANNEL_BITS-1:0] dest,
  output logic                    ch_req,
  output logic [SIZE-1:0]         ch_flit,
  input  logic                    ch_ack,
  output logic                    pkt_sent,
  output logic                    busy
);

  localparam int unsigned SEQ_W    = SIZE - CHANNEL_BITS;
  localparam int unsigned IDX_W    = $clog2(PKT_LEN);
  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
`ifdef PACKET_SOURCE_CHECKSUM_EN
    ST_TAIL,
`endif
    ST_GAP
  } state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [SIZE-1:0]    flit_q, flit_d;
  logic               sent_q, sent_d;
  logic               busy_q, busy_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
`ifdef PACKET_SOURCE_CHECKSUM_EN
  logic [SIZE-1:0]    csum_q, csum_d;
`endif
  logic               xfer;
  logic               eop;

  // Body flit payload: (seq*PKT_LEN + idx) mod 2^SIZE
  function automatic logic [SIZE-1:0] body_flit(input logic [SEQ_W-1:0] s,
                                                 input logic [IDX_W-1:0] i);
    return SIZE'(s) * SIZE'(PKT_LEN) + SIZE'(i);
  endfunction

  assign xfer = req_q & ch_ack;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    flit_d  = flit_q;
    sent_d  = 1'b0;
    busy_d  = busy_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    gcnt_d  = gcnt_q;
`ifdef PACKET_SOURCE_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    eop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_HEAD;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          flit_d  = {dest, seq_q};
        end
      end
      ST_HEAD: begin
        if (xfer) begin
          state_d = ST_BODY;
          idx_d   = IDX_W'(1);
          flit_d  = body_flit(seq_q, IDX_W'(1));
`ifdef PACKET_SOURCE_CHECKSUM_EN
          csum_d  = flit_q;
`endif
        end
      end
      ST_BODY: begin
        if (xfer) begin
`ifdef PACKET_SOURCE_CHECKSUM_EN
          csum_d = csum_q ^ flit_q;
`endif
          if (idx_q == IDX_W'(PKT_LEN - 1)) begin
`ifdef PACKET_SOURCE_CHECKSUM_EN
            state_d = ST_TAIL;
            flit_d  = csum_q ^ flit_q;
`else
            eop     = 1'b1;
`endif
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            flit_d = body_flit(seq_q, idx_q + IDX_W'(1));
          end
        end
      end
`ifdef PACKET_SOURCE_CHECKSUM_EN
      ST_TAIL: begin
        if (xfer) eop = 1'b1;
      end
`endif
      ST_GAP: begin
        if (gcnt_q == GAP_W'(GAP_LAST)) state_d = ST_IDLE;
        else                            gcnt_d  = gcnt_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared end-of-packet bookkeeping for the last flit transfer
    if (eop) begin
      state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
      req_d   = 1'b0;
      busy_d  = 1'b0;
      sent_d  = 1'b1;
      seq_d   = seq_q + SEQ_W'(1);
      gcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      flit_q  <= '0;
      sent_q  <= 1'b0;
      busy_q  <= 1'b0;
      seq_q   <= '0;
      idx_q   <= '0;
      gcnt_q  <= '0;
`ifdef PACKET_SOURCE_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      flit_q  <= flit_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      gcnt_q  <= gcnt_d;
`ifdef PACKET_SOURCE_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign ch_req   = req_q;
  assign ch_flit  = flit_q;
  assign pkt_sent = sent_q;
  assign busy     = busy_q;

endmodule
